alu_uart_initiator: RTL

//  Host-side initiator for the ALU-over-UART test protocol. Takes one command
//  (op, params, operand A, operand B) and sends it as a 6-byte frame through a

---
 rtl/alu_uart_initiator.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_uart_initiator.sv
// ALU-over-UART host initiator: sends a 6-byte command frame through a uart
// transmit port, then collects the 3-byte response (result lo, result hi, flags).
module alu_uart_initiator #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_op,
    input  logic [3:0]  cmd_params,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [7:0]  TXbuffer,
    output logic        TXstart,
    input  logic        TXbusy,
    input  logic [7:0]  RXbuffer,
    input  logic        RXready,
    output logic        rsp_valid,
    output logic [15:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_timeout,
    output logic        rsp_stray
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // SEND  | waiting for TXbusy low, then strobe one frame byte
    // GAP   | one-cycle pause so the uart can raise TXbusy
    // RECV  | collecting response bytes, idle timer running
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] RECV = 2'd3;

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    r_state;
    logic [47:0]   r_frame;
    logic [2:0]    r_idx;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_rx_lo;
    logic [7:0]    r_rx_hi;
    logic [7:0]    r_tx_buffer;
    logic          r_tx_start;
    logic          r_rsp_valid;
    logic [15:0]   r_rsp_result;
    logic          r_rsp_overflow;
    logic          r_rsp_timeout;
    logic          r_rsp_stray;

    logic [7:0]    w_tx_byte;

    always_comb begin
        w_tx_byte = r_frame[7:0];
        case (r_idx)
            3'd1:    w_tx_byte = r_frame[15:8];
            3'd2:    w_tx_byte = r_frame[23:16];
            3'd3:    w_tx_byte = r_frame[31:24];
            3'd4:    w_tx_byte = r_frame[39:32];
            3'd5:    w_tx_byte = r_frame[47:40];
            default: w_tx_byte = r_frame[7:0];
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= IDLE;
            r_frame        <= '0;
            r_idx          <= '0;
            r_timer        <= '0;
            r_rx_lo        <= '0;
            r_rx_hi        <= '0;
            r_tx_buffer    <= '0;
            r_tx_start     <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_timeout  <= 1'b0;
            r_rsp_stray    <= 1'b0;
        end else begin
            r_tx_start  <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_frame        <= {cmd_b, cmd_a, 4'b0, cmd_params, 2'b0, cmd_op};
                        r_idx          <= '0;
                        r_rsp_stray    <= 1'b0;
                        r_rsp_timeout  <= 1'b0;
                        r_rsp_overflow <= 1'b0;
                        r_state        <= SEND;
                    end
                end
                SEND: begin
                    if (RXready) r_rsp_stray <= 1'b1;
                    if (!TXbusy) begin
                        r_tx_buffer <= w_tx_byte;
                        r_tx_start  <= 1'b1;
                        r_state     <= GAP;
                    end
                end
                GAP: begin
                    if (RXready) r_rsp_stray <= 1'b1;
                    if (r_idx == 3'd5) begin
                        r_idx   <= '0;
                        r_timer <= '0;
                        r_state <= RECV;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= SEND;
                    end
                end
                RECV: begin
                    // A byte arriving on the timeout cycle still counts.
                    if (RXready) begin
                        r_timer <= '0;
                        r_idx   <= r_idx + 3'd1;
                        case (r_idx)
                            3'd0: r_rx_lo <= RXbuffer;
                            3'd1: r_rx_hi <= RXbuffer;
                            default: begin
                                r_rsp_valid    <= 1'b1;
                                r_rsp_result   <= {r_rx_hi, r_rx_lo};
                                r_rsp_overflow <= RXbuffer[0];
                                r_rsp_timeout  <= 1'b0;
                                r_idx          <= '0;
                                r_state        <= IDLE;
                            end
                        endcase
                    end else if (r_timer == TIMER_LAST) begin
                        r_rsp_valid    <= 1'b1;
                        r_rsp_timeout  <= 1'b1;
                        r_rsp_result   <= '0;
                        r_rsp_overflow <= 1'b0;
                        r_idx          <= '0;
                        r_state        <= IDLE;
                    end else if (r_timer != {TW{1'b1}}) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready    = (r_state == IDLE);
    assign TXbuffer     = r_tx_buffer;
    assign TXstart      = r_tx_start;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_timeout  = r_rsp_timeout;
    assign rsp_stray    = r_rsp_stray;

endmodule
